// File: rtl/mul_hilo_if.sv
// Handshake and data bundle between the datapath controller and the HI/LO multiply unit.
interface mul_hilo_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [4:0]       alucontrol;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, alucontrol, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, alucontrol, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mul_hilo_unit.sv
// Radix-2 shift-add multiplier writing a 2*WIDTH-bit product into HI/LO, with mthi/mtlo writes.
// Signed operands are multiplied as magnitudes and the product is negated at write-back.
module mul_hilo_unit #(
   parameter int         WIDTH    = 32,
   parameter logic [4:0] OP_MULT  = 5'b10011,
   parameter logic [4:0] OP_MULTU = 5'b10101
) (
   input  logic        clk,
   input  logic        reset,
   mul_hilo_if.slave   bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [WIDTH-1:0]       mcand;
   logic [2*WIDTH:0]       acc;
   logic [2*WIDTH:0]       acc_nxt;
   logic [WIDTH:0]         sum;
   logic                   neg;
   logic                   is_mul;
   logic                   start_ok;
   logic                   busy_c;
   logic                   wr_prod;
   logic                   done_r;
   logic [WIDTH-1:0]       hi_r;
   logic [WIDTH-1:0]       lo_r;

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      u = v;
      return v[WIDTH-1] ? ('0 - u) : u;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                     input logic             n);
      return n ? ('0 - p) : p;
   endfunction

   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      wr_prod   = 1'b0;
      is_mul    = (bus.alucontrol == OP_MULT) || (bus.alucontrol == OP_MULTU);
      start_ok  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && is_mul) begin
               start_ok  = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            busy_c = 1'b1;
            if (cnt == LAST) state_nxt = WRITE;
         end
         WRITE: begin
            busy_c    = 1'b1;
            wr_prod   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // One iteration: conditional add into the upper half, then shift right.
   always_comb begin
      sum     = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
      acc_nxt = acc[0] ? ({sum, acc[WIDTH-1:0]} >> 1) : (acc >> 1);
   end

   // Operand/accumulator datapath carries no reset; control below gates its use.
   always_ff @(posedge clk) begin
      if (start_ok) begin
         if (bus.alucontrol == OP_MULT) begin
            mcand <= magnitude(bus.a);
            acc   <= {{(WIDTH+1){1'b0}}, magnitude(bus.b)};
            neg   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
         end else begin
            mcand <= bus.a;
            acc   <= {{(WIDTH+1){1'b0}}, bus.b};
            neg   <= 1'b0;
         end
      end else if (state == CALC) begin
         acc <= acc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         done_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else begin
         done_r <= wr_prod;
         if (state == IDLE) begin
            cnt <= '0;
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
         end else if (state == CALC) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (wr_prod) {hi_r, lo_r} <= apply_sign(acc[2*WIDTH-1:0], neg);
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed bench for mul_hilo_unit: signed/unsigned products, latency, ignored inputs, reset abort.
module tb_mul_hilo_unit;
   localparam logic [4:0] OP_MULT  = 5'b10011;
   localparam logic [4:0] OP_MULTU = 5'b10101;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   mul_hilo_if #(.WIDTH(32)) m ();

   mul_hilo_unit #(.WIDTH(32), .OP_MULT(OP_MULT), .OP_MULTU(OP_MULTU)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (m)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the request is sampled on the following posedge.
   task automatic start_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
      m.start = 1'b1; m.alucontrol = op; m.a = av; m.b = bv;
      @(posedge clk); #1;
      m.start = 1'b0; m.alucontrol = 5'b00000;
   endtask

   task automatic wait_done(output int bcyc, output int overlap, output int seen);
      bcyc = 0; overlap = 0; seen = 0;
      for (int i = 0; i < 60 && seen == 0; i++) begin
         @(negedge clk);
         if (m.busy) bcyc++;
         if (m.done) begin
            seen = 1;
            if (m.busy) overlap++;
         end
      end
   endtask

   task automatic run_mul(input string tag, input logic [4:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp);
      int bcyc, ov, seen;
      @(negedge clk);
      start_op(op, av, bv);
      wait_done(bcyc, ov, seen);
      chk({tag, "_seen"}, 64'(seen), 64'd1);
      chk({tag, "_busy"}, 64'(bcyc), 64'd33);
      chk({tag, "_ovl"}, 64'(ov), 64'd0);
      chk({tag, "_prod"}, {m.hi, m.lo}, exp);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(m.done), 64'd0);
   endtask

   initial begin
      int bcyc, ov, seen, dcnt;
      reset = 1'b1;
      m.start = 1'b0; m.alucontrol = 5'b0; m.a = '0; m.b = '0;
      m.hi_we = 1'b0; m.lo_we = 1'b0; m.wdata = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_hi", 64'(m.hi), 64'd0);
      chk("rst_lo", 64'(m.lo), 64'd0);
      chk("rst_busy", 64'(m.busy), 64'd0);
      chk("rst_done", 64'(m.done), 64'd0);

      run_mul("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_mul("mult_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      run_mul("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
      run_mul("mult_min2", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_mul("multu_min2", OP_MULTU, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_mul("mult_minx1", OP_MULT, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

      // Inputs during a multiply must have no effect.
      @(negedge clk);
      start_op(OP_MULTU, 32'd7, 32'd6);
      repeat (4) @(negedge clk);
      m.a = 32'd100; m.b = 32'd200; m.start = 1'b1; m.alucontrol = OP_MULT;
      m.hi_we = 1'b1; m.wdata = 32'hDEAD;
      @(negedge clk);
      m.start = 1'b0; m.hi_we = 1'b0; m.alucontrol = 5'b0;
      chk("busy_hi_hold", 64'(m.hi), 64'hFFFF_FFFF);
      wait_done(bcyc, ov, seen);
      chk("busy_seen", 64'(seen), 64'd1);
      chk("busy_cycles", 64'(bcyc), 64'd28);
      chk("busy_prod", {m.hi, m.lo}, 64'd42);
      @(negedge clk);
      chk("busy_noqueue", 64'(m.busy), 64'd0);

      // Direct writes and a non-multiply start in IDLE.
      m.hi_we = 1'b1; m.wdata = 32'h1234;
      @(negedge clk);
      m.hi_we = 1'b0; m.lo_we = 1'b1; m.wdata = 32'h5678;
      @(negedge clk);
      m.lo_we = 1'b0;
      chk("mt_hilo", {m.hi, m.lo}, 64'h0000_1234_0000_5678);
      chk("mt_done", 64'(m.done), 64'd0);
      start_op(5'b00010, 32'd9, 32'd9);
      dcnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (m.busy || m.done) dcnt++;
      end
      chk("badop_quiet", 64'(dcnt), 64'd0);
      chk("badop_hilo", {m.hi, m.lo}, 64'h0000_1234_0000_5678);

      // Reset mid-multiply discards the operation.
      start_op(OP_MULTU, 32'd3, 32'd3);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 64'(m.busy), 64'd0);
      chk("abort_hilo", {m.hi, m.lo}, 64'd0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m.done || m.busy) dcnt++;
      end
      chk("abort_nodone", 64'(dcnt), 64'd0);
      run_mul("after_abort", OP_MULTU, 32'd3, 32'd3, 64'd9);

      // Direct write and start together, then back-to-back start in the done cycle.
      m.hi_we = 1'b1; m.wdata = 32'hAAAA;
      start_op(OP_MULTU, 32'd2, 32'd2);
      m.hi_we = 1'b0;
      @(negedge clk);
      chk("wr_start_hi", 64'(m.hi), 64'hAAAA);
      wait_done(bcyc, ov, seen);
      chk("wr_start_prod", {m.hi, m.lo}, 64'd4);
      start_op(OP_MULT, 32'hFFFF_FFFE, 32'd4);
      wait_done(bcyc, ov, seen);
      chk("b2b_seen", 64'(seen), 64'd1);
      chk("b2b_busy", 64'(bcyc), 64'd33);
      chk("b2b_prod", {m.hi, m.lo}, 64'hFFFF_FFFF_FFFF_FFF8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
